muldiv_iter: RTL and testbench

Parametrised, clocked successor to the combinational multiply unit: executes all eight RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind a start/busy/done handshake. Multiplies complete in one cycle. Divides and remainders use a radix-2 restoring iterative divider taking DWIDTH cycles. It sits in the execute stage beside the ALU; the control unit stalls the pipeline while `busy` is high.

---
 rtl/muldiv_iter_if.sv | 23 ++
 rtl/muldiv_iter.sv | 156 +++++++++++++++
 tb/tb_muldiv_iter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute-stage control and the iterative mul/div unit.
// Handshake: start is taken on a rising edge while busy=0; done pulses for one cycle with MDOut valid.
interface muldiv_iter_if #(
    parameter int DWIDTH = 32
);
    logic              start;
    logic [2:0]        MDFunc;
    logic [DWIDTH-1:0] A;
    logic [DWIDTH-1:0] B;
    logic [DWIDTH-1:0] MDOut;
    logic              busy;
    logic              done;

    modport master (
        output start, MDFunc, A, B,
        input  MDOut, busy, done
    );

    modport slave (
        input  start, MDFunc, A, B,
        output MDOut, busy, done
    );
endinterface

// File: rtl/muldiv_iter.sv
// RISC-V M-extension unit: single-cycle multiplies, radix-2 restoring divider taking DWIDTH cycles.
// FIXQ=1 makes the high-half multiplies return the Q1.(DWIDTH-1) product used by the audio path.
module muldiv_iter #(
    parameter int DWIDTH = 32,
    parameter bit FIXQ   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    muldiv_iter_if.slave     bus,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(DWIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] md_out;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] dvd;
    logic [DWIDTH-1:0] dvs;
    logic [DWIDTH-1:0] rem;
    logic              q_neg;
    logic              r_neg;
    logic              op_rem;

    logic                a_signed;
    logic                b_signed;
    logic [2*DWIDTH-1:0] a_ext;
    logic [2*DWIDTH-1:0] b_ext;
    logic [2*DWIDTH-1:0] prod;
    logic [DWIDTH-1:0]   mul_res;

    always_comb begin
        a_signed = (bus.MDFunc[1:0] != 2'b11);
        b_signed = (bus.MDFunc[1] == 1'b0);
        a_ext    = {{DWIDTH{a_signed & bus.A[DWIDTH-1]}}, bus.A};
        b_ext    = {{DWIDTH{b_signed & bus.B[DWIDTH-1]}}, bus.B};
        // Truncated 2W-bit product of sign/zero-extended operands is exact for every signedness mix.
        prod     = a_ext * b_ext;
        if (bus.MDFunc[1:0] == 2'b00)
            mul_res = prod[DWIDTH-1:0];
        else if (FIXQ)
            mul_res = prod[2*DWIDTH-2:DWIDTH-1];
        else
            mul_res = prod[2*DWIDTH-1:DWIDTH];
    end

    logic              div_signed;
    logic              is_rem;
    logic              b_zero;
    logic              ovf;
    logic [DWIDTH-1:0] fast_res;
    logic [DWIDTH-1:0] abs_a;
    logic [DWIDTH-1:0] abs_b;

    always_comb begin
        div_signed = ~bus.MDFunc[0];
        is_rem     = bus.MDFunc[1];
        b_zero     = (bus.B == '0);
        ovf        = div_signed && (bus.A == {1'b1, {(DWIDTH-1){1'b0}}}) && (bus.B == '1);
        if (b_zero)
            fast_res = is_rem ? bus.A : '1;
        else
            fast_res = is_rem ? '0 : bus.A;
        abs_a = (div_signed && bus.A[DWIDTH-1]) ? -bus.A : bus.A;
        abs_b = (div_signed && bus.B[DWIDTH-1]) ? -bus.B : bus.B;
    end

    logic [DWIDTH:0]   rem_sh;
    logic              ge;
    logic [DWIDTH-1:0] rem_nx;
    logic [DWIDTH-1:0] quo_nx;
    logic [DWIDTH-1:0] q_fin;
    logic [DWIDTH-1:0] r_fin;

    // The dividend register doubles as the quotient: quotient bits shift in as dividend bits shift out.
    always_comb begin
        rem_sh = {rem, dvd[DWIDTH-1]};
        ge     = (rem_sh >= {1'b0, dvs});
        rem_nx = ge ? (rem_sh[DWIDTH-1:0] - dvs) : rem_sh[DWIDTH-1:0];
        quo_nx = {dvd[DWIDTH-2:0], ge};
        q_fin  = q_neg ? -quo_nx : quo_nx;
        r_fin  = (r_neg && (rem_nx != '0)) ? -rem_nx : rem_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_IDLE;
            md_out <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            op_rem <= 1'b0;
        end else begin
            case (state)
                S_DIV: begin
                    dvd <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        md_out <= op_rem ? r_fin : q_fin;
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        if (!bus.MDFunc[2]) begin
                            md_out <= mul_res;
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else if (b_zero || ovf) begin
                            md_out <= fast_res;
                            state  <= S_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            dvd    <= abs_a;
                            dvs    <= abs_b;
                            rem    <= '0;
                            q_neg  <= div_signed & (bus.A[DWIDTH-1] ^ bus.B[DWIDTH-1]);
                            r_neg  <= div_signed & bus.A[DWIDTH-1];
                            op_rem <= is_rem;
                            cnt    <= CW'(DWIDTH);
                            state  <= S_DIV;
                            busy_q <= 1'b1;
                            done_q <= 1'b0;
                        end
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.MDOut = md_out;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed operations on a FIXQ=0 and a FIXQ=1 instance,
// checking result, latency from start and number of busy cycles for every done pulse.
module tb_muldiv_iter;
    localparam int W = 32;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        logic [W-1:0] val;
        int           lat;
        int           bsy;
        int           c0;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter_if #(.DWIDTH(W)) bus0 ();
    muldiv_iter_if #(.DWIDTH(W)) bus1 ();
    logic [1:0] st0;
    logic [1:0] st1;

    muldiv_iter #(.DWIDTH(W), .FIXQ(1'b0)) dut0 (
        .clock(clk), .reset(rst), .bus(bus0), .state_dbg(st0)
    );
    muldiv_iter #(.DWIDTH(W), .FIXQ(1'b1)) dut1 (
        .clock(clk), .reset(rst), .bus(bus1), .state_dbg(st1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   busy_cnt0 = 0;
    int   busy_cnt1 = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.busy) busy_cnt0++;
        if (bus0.done) begin
            if (exp_q0.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done0: got done with MDOut 0x%08h, required no done", bus0.MDOut);
            end else begin
                e = exp_q0.pop_front();
                check(e.name, bus0.MDOut, e.val);
                check({e.name, "_lat"}, W'(cyc - e.c0), W'(e.lat));
                check({e.name, "_busy"}, W'(busy_cnt0), W'(e.bsy));
            end
            busy_cnt0 = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.busy) busy_cnt1++;
        if (bus1.done) begin
            if (exp_q1.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done1: got done with MDOut 0x%08h, required no done", bus1.MDOut);
            end else begin
                e = exp_q1.pop_front();
                check(e.name, bus1.MDOut, e.val);
                check({e.name, "_lat"}, W'(cyc - e.c0), W'(e.lat));
                check({e.name, "_busy"}, W'(busy_cnt1), W'(e.bsy));
            end
            busy_cnt1 = 0;
        end
    end

    task automatic drive(input bit u, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] val, input int lat, input int bsy,
                         input string name);
        exp_t e;
        @(negedge clk);
        e.val = val; e.lat = lat; e.bsy = bsy; e.c0 = cyc; e.name = name;
        if (!u) begin
            bus0.start = 1'b1; bus0.MDFunc = f; bus0.A = a; bus0.B = b;
            if (push) exp_q0.push_back(e);
        end else begin
            bus1.start = 1'b1; bus1.MDFunc = f; bus1.A = a; bus1.B = b;
            if (push) exp_q1.push_back(e);
        end
    endtask

    task automatic release_start;
        @(negedge clk);
        bus0.start = 1'b0; bus0.A = $urandom; bus0.B = $urandom;
        bus0.MDFunc = 3'($urandom_range(0, 7));
        bus1.start = 1'b0; bus1.A = $urandom; bus1.B = $urandom;
        bus1.MDFunc = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || bus0.busy || bus0.done ||
                bus1.busy || bus1.done) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            n_checks++;
            $display("FAIL timeout: %0d/%0d results still pending after 100 cycles, required 0",
                     exp_q0.size(), exp_q1.size());
        end
    endtask

    task automatic op(input bit u, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] val, input int lat, input int bsy, input string name);
        drive(u, f, a, b, 1'b1, val, lat, bsy, name);
        release_start();
        wait_idle();
    endtask

    initial begin
        bus0.start = 1'b0; bus0.MDFunc = '0; bus0.A = '0; bus0.B = '0;
        bus1.start = 1'b0; bus1.MDFunc = '0; bus1.A = '0; bus1.B = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy0", W'(bus0.busy), 0);
        check("rst_done0", W'(bus0.done), 0);
        check("rst_mdout0", bus0.MDOut, 0);
        check("rst_mdout1", bus1.MDOut, 0);
        rst = 1'b0;

        // Multiplies
        op(0, MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0, "mul_7_m3");
        op(0, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, "mulhu_std");
        op(0, MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1, 0, "mulhsu_std");
        op(0, MULH,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1, 0, "mulh_std");
        op(1, MULH,   32'h4000_0000, 32'h4000_0000, 32'h2000_0000, 1, 0, "mulh_q31");
        op(1, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1, 0, "mulhu_q31");

        // Signed divide with a stray start in c10
        drive(0, DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 33, 32, "div_m7_2");
        release_start();
        repeat (9) @(negedge clk);
        bus0.start = 1'b1; bus0.MDFunc = MUL; bus0.A = 32'd1; bus0.B = 32'd1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_idle();

        op(0, REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, "rem_m7_2");
        op(0, DIVU, 32'd100,       32'd7, 32'd14,        33, 32, "divu_100_7");
        op(0, REMU, 32'd100,       32'd7, 32'd2,         33, 32, "remu_100_7");
        op(0, DIV,  32'hFFFF_FFFA, 32'd3, 32'hFFFF_FFFE, 33, 32, "div_m6_3");
        op(0, REM,  32'hFFFF_FFFA, 32'd3, 32'd0,         33, 32, "rem_m6_3");

        // Fast paths
        op(0, DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, "divu_by0");
        op(0, REM,  32'd5,         32'd0,         32'd5,         1, 0, "rem_by0");
        op(0, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        op(0, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0, "rem_ovf");

        // Reset in c10 of a divide, with start also present
        drive(0, DIV, 32'd1000, 32'd3, 1'b0, '0, 0, 0, "div_aborted");
        release_start();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        bus0.start = 1'b1; bus0.MDFunc = MUL; bus0.A = 32'd5; bus0.B = 32'd5;
        @(negedge clk);
        check("abort_busy", W'(bus0.busy), 0);
        check("abort_done", W'(bus0.done), 0);
        check("abort_mdout", bus0.MDOut, 0);
        rst = 1'b0;
        bus0.start = 1'b0;
        busy_cnt0 = 0;
        op(0, MUL, 32'd3, 32'd4, 32'd12, 1, 0, "mul_after_rst");

        // Back-to-back: second start during the DONE cycle
        drive(0, MUL,  32'd3, 32'd4, 1'b1, 32'd12, 1,  0,  "b2b_mul");
        drive(0, DIVU, 32'd9, 32'd3, 1'b1, 32'd3,  33, 32, "b2b_divu");
        release_start();
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
